// File: rtl/node_port_arbiter.sv
// Round-robin wormhole packet arbiter for one router output port: grants one input and holds it from head to tail.
// Optional stall watchdog enabled by defining NODE_ARB_TIMEOUT_EN.
module node_port_arbiter #(
    parameter int N_REQ          = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         tail,
    input  logic                     out_ready,
    output logic [N_REQ-1:0]         grant,
    output logic                     grant_valid,
    output logic [$clog2(N_REQ)-1:0] grant_idx,
    output logic                     xfer,
    output logic                     timeout
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state_q;
    logic [N_REQ-1:0] grant_q;
    logic [IW-1:0]   grant_idx_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   ptr_adv;
    logic [IW-1:0]   sel_idx;
    logic [N_REQ-1:0] sel_onehot;
    logic [N_REQ-1:0] cand_hit;
    logic [IW-1:0]   cand_idx [N_REQ];
    logic            req_g;
    logic            tail_g;

    // cand_idx[gi] is the input sitting gi places after the pointer, wrapped.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
        logic [IW:0] sum;
        assign sum          = {1'b0, ptr_q} + (IW+1)'(gi);
        assign cand_idx[gi] = (sum >= (IW+1)'(N_REQ)) ? IW'(sum - (IW+1)'(N_REQ)) : sum[IW-1:0];
        assign cand_hit[gi] = req[cand_idx[gi]];
        assign sel_onehot[gi] = (sel_idx == IW'(gi));
    end

    always_comb begin
        sel_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                sel_idx = cand_idx[k];
            end
        end
    end

    assign ptr_adv     = (grant_idx_q == IW'(N_REQ - 1)) ? '0 : grant_idx_q + IW'(1);
    assign req_g       = req[grant_idx_q];
    assign tail_g      = tail[grant_idx_q];
    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = |grant_q;
    assign xfer        = grant_valid & req_g & out_ready;

`ifdef NODE_ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
    logic [SW-1:0] stall_q;
    logic          timeout_q;
    assign timeout = timeout_q;
`else
    // Watchdog absent: the comparison is constant false for any legal TIMEOUT_CYCLES.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            ptr_q       <= '0;
`ifdef NODE_ARB_TIMEOUT_EN
            stall_q     <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
`ifdef NODE_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        grant_q     <= sel_onehot;
                        grant_idx_q <= sel_idx;
                        state_q     <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (xfer && tail_g) begin
                        grant_q     <= '0;
                        grant_idx_q <= '0;
                        ptr_q       <= ptr_adv;
                        state_q     <= IDLE;
`ifdef NODE_ARB_TIMEOUT_EN
                        stall_q     <= '0;
`endif
                    end
`ifdef NODE_ARB_TIMEOUT_EN
                    else if (!req_g) begin
                        // Final stalled cycle: force release and give the next input its turn.
                        if (stall_q == SW'(TIMEOUT_CYCLES - 1)) begin
                            grant_q     <= '0;
                            grant_idx_q <= '0;
                            ptr_q       <= ptr_adv;
                            state_q     <= IDLE;
                            stall_q     <= '0;
                            timeout_q   <= 1'b1;
                        end else begin
                            stall_q <= stall_q + SW'(1);
                        end
                    end else begin
                        stall_q <= '0;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_node_port_arbiter.sv
// Self-checking bench for node_port_arbiter: per-cycle vector table plus hand-written corner sequences.
module tb_node_port_arbiter;
`ifdef NODE_ARB_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 64;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] req = '0;
    logic [4:0] tail = '0;
    logic       out_ready = 1'b0;
    logic [4:0] grant;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic       xfer;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst_before;
        logic [4:0] req;
        logic [4:0] tail;
        logic       rdy;
        logic [4:0] g;
        logic [2:0] idx;
        logic       x;
        logic       to;
        string      name;
    } vec_t;

    typedef struct {
        logic [4:0] g;
        logic [2:0] idx;
        logic       x;
        logic       to;
        string      name;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    node_port_arbiter #(.N_REQ(5), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .tail(tail), .out_ready(out_ready),
        .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx),
        .xfer(xfer), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [4:0] rq, input logic [4:0] tl,
                                input logic rd, input logic [4:0] g, input logic [2:0] idx,
                                input logic x, input logic to, input string name);
        vec_t v;
        v.rst_before = r; v.req = rq; v.tail = tl; v.rdy = rd;
        v.g = g; v.idx = idx; v.x = x; v.to = to; v.name = name;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; tail = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One cycle: drive inputs, queue expectation, compare at the falling edge.
    task automatic step(input vec_t v);
        exp_t e;
        req = v.req; tail = v.tail; out_ready = v.rdy;
        e.g = v.g; e.idx = v.idx; e.x = v.x; e.to = v.to; e.name = v.name;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk({v.name, ".sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({e.name, ".grant"}, 32'(grant), 32'(e.g));
            chk({e.name, ".grant_valid"}, 32'(grant_valid), 32'(|e.g));
            chk({e.name, ".grant_idx"}, 32'(grant_idx), 32'(e.idx));
            chk({e.name, ".xfer"}, 32'(xfer), 32'(e.x));
            chk({e.name, ".timeout"}, 32'(timeout), 32'(e.to));
        end
        $display("cycle %s req=%b tail=%b rdy=%b -> grant=%b idx=%0d xfer=%b to=%b",
                 v.name, v.req, v.tail, v.rdy, grant, grant_idx, xfer, timeout);
        @(posedge clk); #1;
    endtask

    initial begin
        // Single-flit packet from input 2.
        tbl.push_back(mk(1, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, "rst_state"));
        tbl.push_back(mk(0, 5'b00100, 5'b00100, 1, 5'b00000, 0, 0, 0, "sf_c0"));
        tbl.push_back(mk(0, 5'b00100, 5'b00100, 1, 5'b00100, 2, 1, 0, "sf_c1"));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, "sf_c2"));
        // Round robin with every input requesting single-flit packets.
        for (int j = 0; j < 6; j++) begin
            tbl.push_back(mk(j == 0, 5'b11111, 5'b11111, 1, 5'b00000, 0, 0, 0, $sformatf("rr_idle%0d", j)));
            tbl.push_back(mk(0, 5'b11111, 5'b11111, 1, 5'(1 << (j % 5)), 3'(j % 5), 1, 0,
                             $sformatf("rr_g%0d", j)));
        end
        // Input 1 four-flit packet while input 3 waits.
        tbl.push_back(mk(1, 5'b01010, 5'b00000, 1, 5'b00000, 0, 0, 0, "lk_c0"));
        for (int j = 1; j <= 3; j++)
            tbl.push_back(mk(0, 5'b01010, 5'b00000, 1, 5'b00010, 1, 1, 0, $sformatf("lk_c%0d", j)));
        tbl.push_back(mk(0, 5'b01010, 5'b00010, 1, 5'b00010, 1, 1, 0, "lk_tail"));
        tbl.push_back(mk(0, 5'b01000, 5'b00000, 1, 5'b00000, 0, 0, 0, "lk_dead"));
        tbl.push_back(mk(0, 5'b01000, 5'b01000, 1, 5'b01000, 3, 1, 0, "lk_g3"));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, "lk_end"));
        // Backpressure: input 4 (pointer now 4), out_ready low for 10 cycles.
        tbl.push_back(mk(0, 5'b10000, 5'b00000, 1, 5'b00000, 0, 0, 0, "bp_c0"));
        tbl.push_back(mk(0, 5'b10000, 5'b00000, 1, 5'b10000, 4, 1, 0, "bp_c1"));
        for (int j = 0; j < 10; j++)
            tbl.push_back(mk(0, 5'b10000, 5'b10000, 0, 5'b10000, 4, 0, 0, $sformatf("bp_stall%0d", j)));
        tbl.push_back(mk(0, 5'b10000, 5'b10000, 1, 5'b10000, 4, 1, 0, "bp_tail"));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, "bp_end"));

        do_reset();
        foreach (tbl[i]) begin
            if (tbl[i].rst_before) do_reset();
            step(tbl[i]);
        end

        // Upstream bubble on a locked grant.
        do_reset();
        step(mk(0, 5'b00001, 5'b00000, 1, 5'b00000, 0, 0, 0, "st_c0"));
        step(mk(0, 5'b00001, 5'b00000, 1, 5'b00001, 0, 1, 0, "st_c1"));
`ifdef NODE_ARB_TIMEOUT_EN
        for (int j = 0; j < 4; j++)
            step(mk(0, 5'b00000, 5'b00000, 1, 5'b00001, 0, 0, 0, $sformatf("st_bub%0d", j)));
        step(mk(0, 5'b11111, 5'b00000, 1, 5'b00000, 0, 0, 1, "st_timeout"));
        step(mk(0, 5'b11111, 5'b00000, 1, 5'b00010, 1, 1, 0, "st_ptr1"));
`else
        for (int j = 0; j < 100; j++)
            step(mk(0, 5'b00000, 5'b00000, 1, 5'b00001, 0, 0, 0, $sformatf("st_hold%0d", j)));
        step(mk(0, 5'b00001, 5'b00001, 1, 5'b00001, 0, 1, 0, "st_tail"));
        step(mk(0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, "st_end"));
`endif

        // Asynchronous reset mid-packet with pointer at 4.
        do_reset();
        step(mk(0, 5'b01000, 5'b01000, 1, 5'b00000, 0, 0, 0, "ar_c0"));
        step(mk(0, 5'b01000, 5'b01000, 1, 5'b01000, 3, 1, 0, "ar_c1"));
        step(mk(0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, "ar_c2"));
        step(mk(0, 5'b10000, 5'b00000, 1, 5'b00000, 0, 0, 0, "ar_c3"));
        step(mk(0, 5'b10000, 5'b00000, 1, 5'b10000, 4, 1, 0, "ar_c4"));
        #1;
        rst = 1'b1; req = '0; tail = '0;
        #1;
        chk("ar_async.grant", 32'(grant), 0);
        chk("ar_async.grant_valid", 32'(grant_valid), 0);
        chk("ar_async.grant_idx", 32'(grant_idx), 0);
        $display("cycle ar_async grant=%b valid=%b idx=%0d", grant, grant_valid, grant_idx);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        step(mk(0, 5'b11000, 5'b01000, 1, 5'b00000, 0, 0, 0, "ar_r0"));
        step(mk(0, 5'b11000, 5'b01000, 1, 5'b01000, 3, 1, 0, "ar_r1"));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/node_port_arbiter.md
# node_port_arbiter

Per-output-port packet arbiter for a mesh router node. It shares one node output link among `N_REQ` input requesters: the four neighbour inputs plus the local injection port. It grants round-robin and holds the grant for a whole wormhole packet (head to tail). Each router node instantiates one arbiter per output direction, in front of the output crossbar mux.

## Interface
- `N_REQ`, 5, number of requesting inputs (NORTH, SOUTH, EAST, WEST, LOCAL)
- `TIMEOUT_CYCLES`, 64, stall limit for a locked grant; only used with `NODE_ARB_TIMEOUT_EN`
- `clk`  in  1  single clock; all state changes on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req`  in  N_REQ  bit i: input i holds a flit routed to this output
- `tail`  in  N_REQ  bit i: input i's current flit is the last of its packet
- `out_ready`  in  1  downstream link can accept a flit this cycle
- `grant`  out  N_REQ  one-hot registered grant; all zero when idle
- `grant_valid`  out  1  OR of `grant`
- `grant_idx`  out  $clog2(N_REQ)  index of the granted input; 0 when idle
- `xfer`  out  1  combinational: a flit moves this cycle
- `timeout`  out  1  one-cycle pulse on forced release; tied 0 without the macro

## Operation
- FSM states: IDLE and LOCKED.
- IDLE:
  - If `req` is non-zero, select the first requester at or after `ptr`, scanning upward modulo `N_REQ`.
  - Register the grant one-hot and go to LOCKED.
  - `ptr` does not change in IDLE.
- LOCKED:
  - `grant` is held constant. Other requests are ignored.
  - `xfer = grant_valid & req[grant_idx] & out_ready`.
  - If `xfer & tail[grant_idx]`: clear the grant, set `ptr = (grant_idx+1) mod N_REQ` and go to IDLE.
  - If `req[grant_idx]` drops mid-packet (upstream bubble), hold the lock. `xfer` is 0 that cycle.
- Round-robin pointer:
  - `$clog2(N_REQ)` bits.
  - Wrap is explicit: `N_REQ-1` goes to 0. Values at or above `N_REQ` are never reachable.
- A single-flit packet (head and tail asserted together) is granted, transferred and released like any other packet.
- `tail` is sampled only for the granted input and only on a transfer cycle.
- Reset values:
  - `grant=0`, `grant_valid=0`, `grant_idx=0`, `timeout=0`.
  - State IDLE, `ptr=0`, stall counter 0.
- Reset mid-packet aborts the lock immediately (asynchronous). The packet tail is the upstream's responsibility.

## Timing
- Arbitration latency: `req` first seen high in IDLE at edge N gives `grant` high after edge N (visible in cycle N+1). The first `xfer` is possible in cycle N+1.
- Throughput while locked: one flit per cycle whenever `req[g]` and `out_ready` are both high.
- Release: a tail transfer in cycle T clears `grant` in cycle T+1 (IDLE). The next grant appears in cycle T+2. One dead cycle between packets is the specified behaviour.
- A simultaneous request from every input in IDLE grants the input at `ptr`.
- `out_ready` low freezes progress only. Grant, pointer and state are unchanged.

## Configuration
- `NODE_ARB_TIMEOUT_EN` defined:
  - A stall counter of `$clog2(TIMEOUT_CYCLES+1)` bits counts LOCKED cycles in which `req[grant_idx]` is 0.
  - It resets to 0 on any cycle where `req[grant_idx]` is 1, and on any release.
  - When it reaches `TIMEOUT_CYCLES`: pulse `timeout` for one cycle, clear the grant, advance `ptr` as on a tail, and go to IDLE.
- `NODE_ARB_TIMEOUT_EN` undefined: no counter is built, `timeout` is constant 0, and a lock is held indefinitely until its tail transfers.

## Test plan
- Reset, then `req=5'b00100` with `tail=5'b00100` and `out_ready=1` in cycle 0: `grant=5'b00100` and `grant_idx=2` in cycle 1; `xfer=1` in cycle 1; `grant=0` in cycle 2.
- `req=5'b11111` held, every flit a tail, `out_ready=1`: grants go 0,1,2,3,4,0 with one idle cycle between each.
- Input 1 granted with a 4-flit packet while input 3 requests: input 3 is not granted until cycle T+2 after input 1's tail transfer; `grant` is stable throughout.
- `out_ready` low for 10 cycles mid-packet: `xfer=0`, grant unchanged, no `timeout`; the packet completes after `out_ready` rises.
- With `NODE_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES=4`: input 0 granted, then `req[0]` dropped. After 4 stalled cycles `timeout` pulses for 1 cycle, `grant=0`, and `ptr=1`. Without the macro, the grant persists for 100 cycles.
- Assert `rst` asynchronously mid-packet: `grant`, `grant_valid` and `grant_idx` are 0 before the next clock edge; after release, the first request from input 3 is granted even though `ptr` was previously 4.
